wide_add_sequencer: RTL

Multi-precision add controller that sequences the existing combinational `N_bit_adder` slice over a WORDS×N-bit operand pair, least-significant slice first, with the carry registered between slices. It accepts one request through a valid/ready handshake, runs WORDS adder passes, and presents a registered result through a second valid/ready handshake. It sits between a requester wanting wide sums, such as a 64-bit accumulator, and the single shared 16-bit adder datapath, so no wide adder is built.

---
 rtl/wide_add_pkg.sv | 14 +
 rtl/N_bit_adder.sv | 16 +
 rtl/wide_add_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// Shared definitions for the multi-precision add sequencer: the controller
// state encoding and the default slice geometry (4 x 16-bit = 64-bit sums).
package wide_add_pkg;

   localparam int N_DEFAULT     = 16;
   localparam int WORDS_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/N_bit_adder.sv
// Combinational N-bit adder slice with carry in and carry out. This is the
// single shared datapath adder that the sequencer time-multiplexes.
module N_bit_adder #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   // One ripple addition; the extra top bit of the result is the carry out.
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add controller: accepts a WORDS*N-bit operand pair, runs
// the shared N-bit adder once per slice (least significant first) with the
// carry registered between slices, then holds the result until it is taken.
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int WORDS = WORDS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [N*WORDS-1:0]   req_a,
   input  logic [N*WORDS-1:0]   req_b,
   input  logic                 req_cin,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [N*WORDS-1:0]   resp_sum,
   output logic                 resp_cout,
   output logic                 busy
);

   localparam int W     = N * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_e           state_q, state_d;
   logic [W-1:0]     opA_q, opA_d;
   logic [W-1:0]     opB_q, opB_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;

   logic [N-1:0]     sliceA;
   logic [N-1:0]     sliceB;
   logic [N-1:0]     sliceSum;
   logic             sliceCout;

   // Select the operand slice addressed by the current index for the adder.
   always_comb begin
      sliceA = '0;
      sliceB = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (idx_q == IDX_W'(w)) begin
            sliceA = opA_q[w*N +: N];
            sliceB = opB_q[w*N +: N];
         end
      end
   end

   N_bit_adder #(
      .N(N)
   ) u_adder (
      .a   (sliceA),
      .b   (sliceB),
      .cin (carry_q),
      .sum (sliceSum),
      .cout(sliceCout)
   );

   // Next-state logic: latch a request in IDLE, one slice per cycle in CALC,
   // hold the result in DONE until the consumer takes it.
   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               opA_d   = req_a;
               opB_d   = req_b;
               carry_d = req_cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            for (int w = 0; w < WORDS; w++) begin
               if (idx_q == IDX_W'(w)) begin
                  sum_d[w*N +: N] = sliceSum;
               end
            end
            carry_d = sliceCout;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      valid_d = (state_d == DONE);
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   // The request side is held off while reset is asserted, even though the
   // state register already reads IDLE.
   assign req_ready  = rst_n && (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign resp_valid = valid_q;
   assign resp_sum   = sum_q;
   assign resp_cout  = carry_q;

endmodule
